mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_D_BURST, default 4, max consecutive data grants while a fetch waits.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_req  in  1  fetch read request, held until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch byte address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  if_rdata valid.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 d_req  in  1  data request, held until d_gnt.
REQ-012 d_we  in  1  1 = write, 0 = read.
REQ-013 d_addr  in  ADDR_W  data byte address.
REQ-014 d_wdata  in  DATA_W  write data.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  d_rdata valid (reads only).
REQ-017 d_rdata  out  DATA_W  data read data.
REQ-018 mem_en  out  1  memory access this cycle.
REQ-019 mem_we  out  1  memory write.
REQ-020 mem_addr  out  ADDR_W  memory byte address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en=1.

Function
REQ-023 At most one of if_gnt, d_gnt SHALL be 1 per cycle; grants, mem_en, mem_we, mem_addr, mem_wdata are combinational from requests and registered state.
REQ-024 Default priority SHALL be data over fetch.
REQ-025 Counter starve_cnt (0..MAX_D_BURST) SHALL increment on every d_gnt cycle with if_req=1, and clear on any if_gnt or any cycle with if_req=0.
REQ-026 When starve_cnt == MAX_D_BURST and if_req=1, fetch SHALL be granted regardless of d_req.
REQ-027 mem_en SHALL equal if_gnt | d_gnt; mem_we = d_gnt & d_we; mem_addr/mem_wdata SHALL come from the granted requester; otherwise mem_addr/mem_wdata = 0.
REQ-028 Registered owner (NONE/IF/D) SHALL record the granted read; a write or idle cycle records NONE.
REQ-029 Next cycle: if owner=IF, if_rvalid=1 and if_rdata=mem_rdata; if owner=D, d_rvalid=1 and d_rdata=mem_rdata; non-owner rdata SHALL be 0.
REQ-030 Read latency SHALL be exactly 1 cycle from grant to rvalid; back-to-back grants SHALL sustain 1 access per cycle.
REQ-031 Data writes SHALL never produce d_rvalid.
REQ-032 Request dropped before grant SHALL be discarded with no side effect.
REQ-033 Simultaneous if_req and d_req with starve_cnt < MAX_D_BURST: d_gnt=1, if_gnt=0.

Reset
REQ-034 On rst: starve_cnt=0, owner=NONE, if_rvalid=d_rvalid=0, rdata outputs 0; with no requests all outputs are 0.
REQ-035 Reset asserted while a read is outstanding SHALL cancel its rvalid; no access resumes after reset.
REQ-036 Grants SHALL be 0 while rst=1.

Structure
REQ-037 Package riscv_mem_pkg SHALL hold owner enum (OWN_NONE, OWN_IF, OWN_D) and the default widths/MAX_D_BURST constants.
REQ-038 Single module, no sub-module; one always_ff for starve_cnt/owner, one always_comb for arbitration and muxing.

Verification
REQ-039 if_req only, if_addr=0x10, mem returns 0x00100073 -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0x00100073.
REQ-040 d_req read 0x2000 and if_req together -> d_gnt, if_gnt=0; next cycle d_rvalid, d_rdata=mem_rdata; fetch granted following cycle.
REQ-041 d_req held 6 cycles with if_req held, MAX_D_BURST=4 -> d_gnt cycles 1-4, if_gnt cycle 5, d_gnt cycle 6.
REQ-042 d_req write 0x2004 data 0xDEADBEEF -> mem_en=mem_we=1, mem_wdata=0xDEADBEEF, no d_rvalid next cycle.
REQ-043 rst pulsed the cycle after a fetch grant -> if_rvalid stays 0, starve_cnt=0, all outputs 0.
REQ-044 Random req traffic 2000 cycles -> never two grants, every read grant yields exactly one rvalid to its owner.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package riscv_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W      = 32;
  localparam int unsigned DEFAULT_DATA_W      = 32;
  localparam int unsigned DEFAULT_MAX_D_BURST = 4;

  // Which requester the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared single-port memory.
interface mem_port_arbiter_if
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter for one memory port shared by fetch and data, with a
// starvation counter that forces a fetch grant after MAX_D_BURST data grants.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned MAX_D_BURST = DEFAULT_MAX_D_BURST
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  // One spare count of headroom keeps the width >= 1 even for MAX_D_BURST = 0.
  localparam int unsigned CntW = $clog2(MAX_D_BURST + 2);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  owner_e          owner_q, owner_d;
  logic            fetch_forced;
  logic            if_gnt, d_gnt;

  always_comb begin
    fetch_forced = bus.if_req && (starve_cnt_q == CntW'(MAX_D_BURST));
    if_gnt       = !rst && bus.if_req && (fetch_forced || !bus.d_req);
    d_gnt        = !rst && bus.d_req && !if_gnt;

    bus.if_gnt = if_gnt;
    bus.d_gnt  = d_gnt;
    bus.mem_en = if_gnt || d_gnt;
    bus.mem_we = d_gnt && bus.d_we;

    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (if_gnt) begin
      bus.mem_addr = bus.if_addr;
    end else if (d_gnt) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end

    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !bus.if_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != CntW'(MAX_D_BURST))) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end

    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !bus.d_we) begin
      owner_d = OWN_D;
    end

    bus.if_rvalid = (owner_q == OWN_IF);
    bus.d_rvalid  = (owner_q == OWN_D);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : {DATA_W{1'b0}};
  end

  // Async clear of owner_q also drops any read response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

endmodule
